// File: rtl/axi_pmu_lat.sv
// Passive AXI performance monitor: channel activity/stall counters, per-ID
// transaction latency statistics and a snapshot bank for coherent readout.

module axi_pmu_lat_trk #(
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned CNT_WIDTH = 48,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic [CNT_WIDTH-1:0] now,
    input  logic                 push,
    input  logic [ID_WIDTH-1:0]  push_id,
    input  logic                 pop,
    input  logic [ID_WIDTH-1:0]  pop_id,
    output logic [CNT_WIDTH-1:0] outstanding,
    output logic [CNT_WIDTH-1:0] lat_sum,
    output logic [CNT_WIDTH-1:0] lat_max,
    output logic [CNT_WIDTH-1:0] lat_min,
    output logic [CNT_WIDTH-1:0] done,
    output logic [CNT_WIDTH-1:0] overflow
);
    localparam int unsigned NUM_ID = 1 << ID_WIDTH;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam logic [CNT_WIDTH-1:0] ONES = '1;

    logic [CNT_WIDTH-1:0] ts_mem [NUM_ID][DEPTH];
    logic [PTR_W-1:0]     rd_ptr [NUM_ID];
    logic [PTR_W-1:0]     wr_ptr [NUM_ID];
    logic [OCC_W-1:0]     occ    [NUM_ID];
    logic [CNT_WIDTH-1:0] skip   [NUM_ID];

    logic                 pop_hit, pop_skip, push_ok, push_skip;
    logic [OCC_W-1:0]     push_occ;
    logic [CNT_WIDTH-1:0] lat;
    logic [CNT_WIDTH:0]   sum_ext;
    logic [NUM_ID-1:0]    push_sel, pop_sel, skip_inc, skip_dec;

    // Per-cycle tracker decisions; a same-ID pop frees its slot before the full check
    always_comb begin
        pop_hit   = pop && (occ[pop_id] != '0);
        pop_skip  = pop && !pop_hit && (skip[pop_id] != '0);
        push_occ  = occ[push_id] - OCC_W'(pop_hit && (pop_id == push_id));
        push_ok   = push && (push_occ != OCC_W'(DEPTH)) && (skip[push_id] == '0);
        push_skip = push && !push_ok;
        lat       = now - ts_mem[pop_id][rd_ptr[pop_id]];
        sum_ext   = {1'b0, lat_sum} + {1'b0, lat};
        for (int i = 0; i < NUM_ID; i++) begin
            push_sel[i] = push_ok   && (push_id == ID_WIDTH'(i));
            pop_sel[i]  = pop_hit   && (pop_id  == ID_WIDTH'(i));
            skip_inc[i] = push_skip && (push_id == ID_WIDTH'(i));
            skip_dec[i] = pop_skip  && (pop_id  == ID_WIDTH'(i));
        end
    end

    // Timestamp FIFOs and skip counters run regardless of en_i/clr_i
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_ID; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                occ[i]    <= '0;
                skip[i]   <= '0;
                for (int j = 0; j < DEPTH; j++) ts_mem[i][j] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ID; i++) begin
                if (push_sel[i]) begin
                    ts_mem[i][wr_ptr[i]] <= now;
                    wr_ptr[i]            <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop_sel[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                occ[i]  <= occ[i] + OCC_W'(push_sel[i]) - OCC_W'(pop_sel[i]);
                skip[i] <= skip[i] + CNT_WIDTH'(skip_inc[i]) - CNT_WIDTH'(skip_dec[i]);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            outstanding <= '0;
        end else if (push && !pop) begin
            outstanding <= outstanding + CNT_WIDTH'(1);
        end else if (pop && !push && (outstanding != '0)) begin
            outstanding <= outstanding - CNT_WIDTH'(1);
        end
    end

    // Latency statistics saturate; clear wins over any same-cycle update
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lat_sum  <= '0;
            lat_max  <= '0;
            lat_min  <= ONES;
            done     <= '0;
            overflow <= '0;
        end else if (clr_i) begin
            lat_sum  <= '0;
            lat_max  <= '0;
            lat_min  <= ONES;
            done     <= '0;
            overflow <= '0;
        end else if (en_i) begin
            if (pop_hit) begin
                lat_sum <= sum_ext[CNT_WIDTH] ? ONES : sum_ext[CNT_WIDTH-1:0];
                if (lat > lat_max) lat_max <= lat;
                if (lat < lat_min) lat_min <= lat;
                if (done != ONES) done <= done + CNT_WIDTH'(1);
            end
            if (push_skip && (overflow != ONES)) overflow <= overflow + CNT_WIDTH'(1);
        end
    end
endmodule

module axi_pmu_lat #(
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned CNT_WIDTH = 48,
    parameter int unsigned DEPTH     = 4,
    parameter bit          SNAPSHOT  = 1'b1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 ar_valid,
    input  logic                 ar_ready,
    input  logic [ID_WIDTH-1:0]  ar_id,
    input  logic                 r_valid,
    input  logic                 r_ready,
    input  logic                 r_last,
    input  logic [ID_WIDTH-1:0]  r_id,
    input  logic                 aw_valid,
    input  logic                 aw_ready,
    input  logic [ID_WIDTH-1:0]  aw_id,
    input  logic                 w_valid,
    input  logic                 w_ready,
    input  logic                 b_valid,
    input  logic                 b_ready,
    input  logic [ID_WIDTH-1:0]  b_id,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 snap_i,
    input  logic [4:0]           addr_i,
    output logic [CNT_WIDTH-1:0] data_o
);
    localparam int unsigned NUM_EV   = 13;
    localparam int unsigned NUM_ADDR = 32;
    localparam logic [CNT_WIDTH-1:0] ONES = '1;

    logic                 arh, rlh, awh, bh;
    logic [CNT_WIDTH-1:0] cyc;
    logic [CNT_WIDTH-1:0] rd_os, rd_sum, rd_max, rd_min, rd_done, rd_ovf;
    logic [CNT_WIDTH-1:0] wr_os, wr_sum, wr_max, wr_min, wr_done, wr_ovf;
    logic [NUM_EV-1:0]    ev_inc;
    logic [CNT_WIDTH-1:0] ev_cnt [NUM_EV];
    logic [CNT_WIDTH-1:0] live   [NUM_ADDR];
    logic [CNT_WIDTH-1:0] shadow [NUM_ADDR];

    assign arh = ar_valid && ar_ready;
    assign rlh = r_valid && r_ready && r_last;
    assign awh = aw_valid && aw_ready;
    assign bh  = b_valid && b_ready;

    axi_pmu_lat_trk #(.ID_WIDTH(ID_WIDTH), .CNT_WIDTH(CNT_WIDTH), .DEPTH(DEPTH)) rd_trk (
        .aclk(aclk), .aresetn(aresetn), .en_i(en_i), .clr_i(clr_i), .now(cyc),
        .push(arh), .push_id(ar_id), .pop(rlh), .pop_id(r_id),
        .outstanding(rd_os), .lat_sum(rd_sum), .lat_max(rd_max), .lat_min(rd_min),
        .done(rd_done), .overflow(rd_ovf)
    );

    axi_pmu_lat_trk #(.ID_WIDTH(ID_WIDTH), .CNT_WIDTH(CNT_WIDTH), .DEPTH(DEPTH)) wr_trk (
        .aclk(aclk), .aresetn(aresetn), .en_i(en_i), .clr_i(clr_i), .now(cyc),
        .push(awh), .push_id(aw_id), .pop(bh), .pop_id(b_id),
        .outstanding(wr_os), .lat_sum(wr_sum), .lat_max(wr_max), .lat_min(wr_min),
        .done(wr_done), .overflow(wr_ovf)
    );

    // Free-running timestamp source
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) cyc <= '0;
        else          cyc <= cyc + CNT_WIDTH'(1);
    end

    always_comb begin
        ev_inc     = '0;
        ev_inc[0]  = !ar_valid && (rd_os == '0);
        ev_inc[1]  = ar_valid && !ar_ready;
        ev_inc[2]  = arh;
        ev_inc[3]  = (rd_os != '0) && !r_valid;
        ev_inc[4]  = r_valid && !r_ready;
        ev_inc[5]  = r_valid && r_ready;
        ev_inc[6]  = !aw_valid && (wr_os == '0);
        ev_inc[7]  = aw_valid && !aw_ready;
        ev_inc[8]  = awh;
        ev_inc[9]  = w_valid && w_ready;
        ev_inc[10] = w_valid && !w_ready;
        ev_inc[11] = bh;
        ev_inc[12] = b_valid && !b_ready;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_EV; i++) ev_cnt[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < NUM_EV; i++) ev_cnt[i] <= '0;
        end else if (en_i) begin
            for (int i = 0; i < NUM_EV; i++) begin
                if (ev_inc[i] && (ev_cnt[i] != ONES)) ev_cnt[i] <= ev_cnt[i] + CNT_WIDTH'(1);
            end
        end
    end

    // Software-visible address map; unused slots read zero
    always_comb begin
        for (int i = 0; i < NUM_ADDR; i++) live[i] = '0;
        live[0]  = ev_cnt[0];
        live[1]  = rd_os;
        live[2]  = ev_cnt[1];
        live[3]  = ev_cnt[2];
        live[4]  = ev_cnt[3];
        live[5]  = ev_cnt[4];
        live[6]  = ev_cnt[5];
        live[7]  = rd_sum;
        live[8]  = rd_max;
        live[9]  = rd_min;
        live[10] = rd_done;
        live[11] = rd_ovf;
        live[12] = ev_cnt[6];
        live[13] = wr_os;
        live[14] = ev_cnt[7];
        live[15] = ev_cnt[8];
        live[16] = ev_cnt[9];
        live[17] = ev_cnt[10];
        live[18] = ev_cnt[11];
        live[19] = ev_cnt[12];
        live[20] = wr_sum;
        live[21] = wr_max;
        live[22] = wr_min;
        live[23] = wr_done;
        live[24] = wr_ovf;
        live[25] = cyc;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_ADDR; i++) shadow[i] <= '0;
        end else if (snap_i) begin
            for (int i = 0; i < NUM_ADDR; i++) shadow[i] <= live[i];
        end
    end

    assign data_o = SNAPSHOT ? shadow[addr_i] : live[addr_i];
endmodule

// File: doc/axi_pmu_lat.md
Name: axi_pmu_lat

Overview:
- Parametrised next-generation AXI performance monitor. Taps one AXI port passively, with no effect on the handshakes it watches.
- Provides the read/write channel activity and stall counters plus per-transaction latency statistics (sum, max, min, completed count).
- Latency is tracked per ID using per-ID timestamp FIFOs.
- Adds saturating counters, enable/clear control and an atomic snapshot bank for coherent software readout through the NoC PMU read mux.

Parameters:
ID_WIDTH, 4, width of ar_id/r_id/aw_id/b_id; 2**ID_WIDTH trackers per direction
CNT_WIDTH, 48, width of every counter, timestamp and data_o
DEPTH, 4, timestamp FIFO entries per ID per direction (power of 2, >=2)
SNAPSHOT, 1, 1: data_o reads the shadow bank; 0: data_o reads live counters

Ports:
aclk  in  1  clock
aresetn  in  1  async active-low reset
ar_valid, ar_ready  in  1  monitored AR handshake
ar_id  in  ID_WIDTH  monitored ARID
r_valid, r_ready, r_last  in  1  monitored R handshake
r_id  in  ID_WIDTH  monitored RID
aw_valid, aw_ready  in  1  monitored AW handshake
aw_id  in  ID_WIDTH  monitored AWID
w_valid, w_ready  in  1  monitored W handshake
b_valid, b_ready  in  1  monitored B handshake
b_id  in  ID_WIDTH  monitored BID
en_i  in  1  statistics count enable
clr_i  in  1  synchronous clear of statistics
snap_i  in  1  copy live counters into shadow bank
addr_i  in  5  counter select
data_o  out  CNT_WIDTH  selected counter, combinational

Behaviour:
- Reset is aresetn, asynchronous, active-low; the clock is aclk.
- Reset values:
  - All counters, shadow registers, FIFOs and skip counters are 0.
  - rd_lat_min and wr_lat_min reset to all-ones.
  - data_o follows the reset state combinationally.
- Handshake terms:
  - ARH = ar_valid&ar_ready; RLH = r_valid&r_ready&r_last; AWH = aw_valid&aw_ready; BH = b_valid&b_ready.
- Address map (shadow or live per SNAPSHOT):
  - Reads: 0 rd_idle, 1 rd_outstanding, 2 ar_stall, 3 ar_hs, 4 rvalid_stall, 5 rready_stall, 6 r_hs, 7 rd_lat_sum, 8 rd_lat_max, 9 rd_lat_min, 10 rd_done, 11 rd_overflow.
  - Writes: 12 wr_idle, 13 wr_outstanding, 14 aw_stall, 15 aw_hs, 16 w_hs, 17 wready_stall, 18 b_hs, 19 bready_stall, 20 wr_lat_sum, 21 wr_lat_max, 22 wr_lat_min, 23 wr_done, 24 wr_overflow.
  - 25 cycle counter; 26-31 read 0.
- Increment conditions (evaluated when en_i=1):
  - rd_idle: !ar_valid & rd_outstanding==0.
  - ar_stall: ar_valid&!ar_ready.
  - rvalid_stall: rd_outstanding!=0 & !r_valid.
  - rready_stall: r_valid&!r_ready.
  - r_hs: r_valid&r_ready.
  - The write-side counters use the same rules with AW/W/B; the write outstanding count is AWH up, BH down.
- Outstanding counters:
  - Always tracked, regardless of en_i.
  - ARH up, RLH down; a simultaneous ARH and RLH leaves the count unchanged.
  - Never decrements below 0 (an orphan completion is ignored).
- Cycle counter: always runs and wraps modulo 2**CNT_WIDTH; it is the timestamp source.
- Statistic counters (everything except outstanding and cycle) saturate at all-ones and never wrap.
- Trackers, one FIFO plus one skip counter per ID per direction:
  - Always active, regardless of en_i.
  - On ARH: if fifo[ar_id] is full or skip[ar_id]!=0, no push; skip[ar_id]++ and rd_overflow++. Otherwise push the timestamp.
  - On RLH: if fifo[r_id] is non-empty, pop, lat = now - ts (mod 2**CNT_WIDTH), then update statistics.
    - Stat update: rd_lat_sum += lat (saturating), rd_lat_max = max, rd_lat_min = min, rd_done++.
    - Otherwise, if skip[r_id]!=0, skip--. Otherwise the completion is an orphan and is ignored.
  - Same-cycle push and pop on the same ID is legal at any occupancy, including full. Pop precedes the full check, so occupancy is unchanged.
  - The write direction is identical, using AWH/aw_id and BH/b_id.
  - Minimum measurable latency is 1 cycle.
- en_i=0: statistic counters hold; trackers, outstanding counters and the cycle counter continue.
  - A transaction that completes while en_i=0 pops its tracker entry but leaves rd_lat_*, rd_done and the write equivalents unchanged.
- clr_i=1: all statistic counters take their reset values at the next edge. clr_i has priority over any same-cycle increment.
  - clr_i does not clear outstanding counts, FIFOs, skip counters or the cycle counter.
- snap_i=1: the shadow bank captures the pre-edge live values at the next edge.
  - snap_i together with clr_i: the shadow bank receives the pre-clear values.

Test Plan:
1. Reset, then read all addresses -> 0, except 9 and 22 which read all-ones. Cycle counter reads N after N edges.
2. Single read: ID3 ARH at cycle 10, RLH on ID3 at cycle 17 -> rd_lat_sum=7, max=7, min=7, rd_done=1, ar_hs=1, rd_outstanding returns to 0.
3. DEPTH=4: issue 6 reads on ID2 with no responses, then 6 RLH on ID2 -> rd_overflow=2, rd_done=4, skip[2]=0, later reads are tracked correctly.
4. Writes: AW ID1 at t=0, AW ID5 at t=2; B ID5 at t=6, B ID1 at t=9 -> wr_lat_sum=13, max=9, min=4, wr_done=2.
5. Control and saturation:
   - Hold ar_valid=1, ar_ready=0 for 5 cycles with en_i=0 for 2 of them -> ar_stall=3.
   - Pulse snap_i and clr_i together -> shadow ar_stall=3, live ar_stall=0.
6. Saturation and ordering:
   - CNT_WIDTH=4: 20 stall cycles -> ar_stall=15.
   - Same-cycle ARH and RLH on a full ID FIFO -> occupancy 4, no overflow.
